// File: rtl/vdma_frame_scheduler.sv
// ---------------------------------------------------------------------------
// vdma_frame_scheduler
//
// Purpose:
//   Hands out DDR frame-buffer base addresses to the VDMA write path and
//   read path. N-buffer rotation (3 or 4 buffers) keeps the writer off the
//   buffer the reader is fetching and off the newest completed frame. The
//   reader always picks up the most recent complete frame and repeats its
//   current frame when nothing newer has been published.
//
// Ports:
//   axi_aclk        clock
//   axi_resetn      synchronous active-low reset
//   enable          when low, event pulses are ignored and state holds
//   wr_frame_start  writer begins a frame / requests a buffer (pulse)
//   wr_frame_done   writer finished its frame (pulse)
//   rd_frame_start  reader begins a frame / requests a buffer (pulse)
//   rd_frame_done   reader finished its frame (pulse)
//   wr_base_addr    registered base address of the writer's buffer
//   wr_index        buffer index held by the writer
//   rd_base_addr    registered base address of the reader's buffer
//   rd_index        buffer index held by the reader
//   rd_frame_valid  reader holds a complete frame
//   rd_new_frame    one-cycle pulse: reader switched to a new frame
//   rd_repeat       one-cycle pulse: reader re-reads its previous frame
//   wr_frame_cnt    completed writer frames (wraps)
//   rd_repeat_cnt   reader repeat events (wraps)
//   wr_abort_cnt    aborted writer frames (wraps)
//
// Events within one cycle are resolved in the order: writer done, reader
// start, writer start. Each stage sees the results of the stages before it.
// ---------------------------------------------------------------------------
module vdma_frame_scheduler #(
    parameter int                ASIZE      = 29,
    parameter int                NUM_FRAMES = 3,
    parameter logic [ASIZE-1:0]  BASE_ADDR  = '0,
    parameter logic [ASIZE-1:0]  FRAME_STEP = ASIZE'(29'h0100000),
    parameter int                CNT_W      = 16
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             enable,
    input  logic             wr_frame_start,
    input  logic             wr_frame_done,
    input  logic             rd_frame_start,
    input  logic             rd_frame_done,
    output logic [ASIZE-1:0] wr_base_addr,
    output logic [1:0]       wr_index,
    output logic [ASIZE-1:0] rd_base_addr,
    output logic [1:0]       rd_index,
    output logic             rd_frame_valid,
    output logic             rd_new_frame,
    output logic             rd_repeat,
    output logic [CNT_W-1:0] wr_frame_cnt,
    output logic [CNT_W-1:0] rd_repeat_cnt,
    output logic [CNT_W-1:0] wr_abort_cnt
);

    typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;
    typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_t;

    localparam logic [1:0] WR_RESET_IDX = 2'(NUM_FRAMES - 1);

    function automatic logic [ASIZE-1:0] addr_of(input logic [1:0] idx);
        return BASE_ADDR + ASIZE'(idx) * FRAME_STEP;
    endfunction

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic [1:0]       wr_index_q, wr_index_d;
    logic [1:0]       rd_index_q, rd_index_d;
    logic [1:0]       latest_idx_q, latest_idx_d;
    logic             latest_valid_q, latest_valid_d;
    logic             rd_frame_valid_q, rd_frame_valid_d;
    logic             rd_new_frame_q, rd_new_frame_d;
    logic             rd_repeat_q, rd_repeat_d;
    logic [ASIZE-1:0] wr_base_addr_q, wr_base_addr_d;
    logic [ASIZE-1:0] rd_base_addr_q, rd_base_addr_d;
    logic [CNT_W-1:0] wr_frame_cnt_q, wr_frame_cnt_d;
    logic [CNT_W-1:0] rd_repeat_cnt_q, rd_repeat_cnt_d;
    logic [CNT_W-1:0] wr_abort_cnt_q, wr_abort_cnt_d;

    // Writer state after the done stage; a start in this state aborts.
    wr_state_t        wr_state_mid;
    logic [NUM_FRAMES-1:0] buf_busy;

    // -----------------------------------------------------------------------
    // Stage 1 + 2: publish a finished writer frame, then serve a reader start
    // against the (possibly just-updated) latest frame.
    // -----------------------------------------------------------------------
    always_comb begin
        latest_idx_d     = latest_idx_q;
        latest_valid_d   = latest_valid_q;
        wr_frame_cnt_d   = wr_frame_cnt_q;
        wr_state_mid     = wr_state_q;
        rd_state_d       = rd_state_q;
        rd_index_d       = rd_index_q;
        rd_frame_valid_d = rd_frame_valid_q;
        rd_new_frame_d   = 1'b0;
        rd_repeat_d      = 1'b0;
        rd_repeat_cnt_d  = rd_repeat_cnt_q;

        if (enable) begin
            if (wr_frame_done && wr_state_q == WR_ACTIVE) begin
                latest_idx_d   = wr_index_q;
                latest_valid_d = 1'b1;
                wr_frame_cnt_d = wr_frame_cnt_q + 1'b1;
                wr_state_mid   = WR_IDLE;
            end

            if (rd_frame_done) begin
                rd_state_d = RD_IDLE;
            end

            // A start in the same cycle as a done overrides the done.
            if (rd_frame_start && latest_valid_d) begin
                if (latest_idx_d != rd_index_q || !rd_frame_valid_q) begin
                    rd_index_d     = latest_idx_d;
                    rd_new_frame_d = 1'b1;
                end else begin
                    rd_repeat_d     = 1'b1;
                    rd_repeat_cnt_d = rd_repeat_cnt_q + 1'b1;
                end
                rd_frame_valid_d = 1'b1;
                rd_state_d       = RD_ACTIVE;
            end
        end
    end

    // A buffer is off-limits to the writer if the reader is fetching it or it
    // holds the newest published frame, both as seen after stages 1 and 2.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FRAMES; gi++) begin : g_busy
            assign buf_busy[gi] =
                (rd_state_d == RD_ACTIVE && rd_index_d == 2'(gi)) ||
                (latest_valid_d && latest_idx_d == 2'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stage 3: writer start. Circular search from the buffer after the one
    // currently held; at most two buffers are busy so one is always free.
    // -----------------------------------------------------------------------
    always_comb begin : wr_select
        int   cand;
        logic found;

        cand           = 0;
        found          = 1'b0;
        wr_state_d     = wr_state_mid;
        wr_index_d     = wr_index_q;
        wr_abort_cnt_d = wr_abort_cnt_q;

        if (enable && wr_frame_start) begin
            if (wr_state_mid == WR_ACTIVE) begin
                wr_abort_cnt_d = wr_abort_cnt_q + 1'b1;
            end
            for (int k = 1; k <= NUM_FRAMES; k++) begin
                cand = (int'(wr_index_q) + k) % NUM_FRAMES;
                if (!found && !buf_busy[cand]) begin
                    found      = 1'b1;
                    wr_index_d = 2'(cand);
                end
            end
            wr_state_d = WR_ACTIVE;
        end
    end

    always_comb begin
        wr_base_addr_d = addr_of(wr_index_d);
        rd_base_addr_d = addr_of(rd_index_d);
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            wr_state_q       <= WR_IDLE;
            rd_state_q       <= RD_IDLE;
            wr_index_q       <= WR_RESET_IDX;
            rd_index_q       <= 2'd0;
            latest_idx_q     <= 2'd0;
            latest_valid_q   <= 1'b0;
            rd_frame_valid_q <= 1'b0;
            rd_new_frame_q   <= 1'b0;
            rd_repeat_q      <= 1'b0;
            wr_base_addr_q   <= addr_of(WR_RESET_IDX);
            rd_base_addr_q   <= addr_of(2'd0);
            wr_frame_cnt_q   <= '0;
            rd_repeat_cnt_q  <= '0;
            wr_abort_cnt_q   <= '0;
        end else begin
            wr_state_q       <= wr_state_d;
            rd_state_q       <= rd_state_d;
            wr_index_q       <= wr_index_d;
            rd_index_q       <= rd_index_d;
            latest_idx_q     <= latest_idx_d;
            latest_valid_q   <= latest_valid_d;
            rd_frame_valid_q <= rd_frame_valid_d;
            rd_new_frame_q   <= rd_new_frame_d;
            rd_repeat_q      <= rd_repeat_d;
            wr_base_addr_q   <= wr_base_addr_d;
            rd_base_addr_q   <= rd_base_addr_d;
            wr_frame_cnt_q   <= wr_frame_cnt_d;
            rd_repeat_cnt_q  <= rd_repeat_cnt_d;
            wr_abort_cnt_q   <= wr_abort_cnt_d;
        end
    end

    assign wr_base_addr   = wr_base_addr_q;
    assign wr_index       = wr_index_q;
    assign rd_base_addr   = rd_base_addr_q;
    assign rd_index       = rd_index_q;
    assign rd_frame_valid = rd_frame_valid_q;
    assign rd_new_frame   = rd_new_frame_q;
    assign rd_repeat      = rd_repeat_q;
    assign wr_frame_cnt   = wr_frame_cnt_q;
    assign rd_repeat_cnt  = rd_repeat_cnt_q;
    assign wr_abort_cnt   = wr_abort_cnt_q;

endmodule

// File: tb/tb_vdma_frame_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for vdma_frame_scheduler (default parameters: 3 buffers,
// base 0, step 0x100000). A behavioural model computes the expected output
// snapshot for every driven cycle and queues it; a monitor pops one snapshot
// per clock and compares every output. A directed sequence walks the main
// scenarios, then randomized events (with occasional enable drops and
// resets) follow.
// ---------------------------------------------------------------------------
module tb_vdma_frame_scheduler;

    localparam int NF = 3;

    logic        clk = 1'b0;
    logic        axi_resetn;
    logic        enable;
    logic        wr_frame_start, wr_frame_done, rd_frame_start, rd_frame_done;
    logic [28:0] wr_base_addr, rd_base_addr;
    logic [1:0]  wr_index, rd_index;
    logic        rd_frame_valid, rd_new_frame, rd_repeat;
    logic [15:0] wr_frame_cnt, rd_repeat_cnt, wr_abort_cnt;

    always #5 clk = ~clk;

    vdma_frame_scheduler dut (
        .axi_aclk       (clk),
        .axi_resetn     (axi_resetn),
        .enable         (enable),
        .wr_frame_start (wr_frame_start),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_start (rd_frame_start),
        .rd_frame_done  (rd_frame_done),
        .wr_base_addr   (wr_base_addr),
        .wr_index       (wr_index),
        .rd_base_addr   (rd_base_addr),
        .rd_index       (rd_index),
        .rd_frame_valid (rd_frame_valid),
        .rd_new_frame   (rd_new_frame),
        .rd_repeat      (rd_repeat),
        .wr_frame_cnt   (wr_frame_cnt),
        .rd_repeat_cnt  (rd_repeat_cnt),
        .wr_abort_cnt   (wr_abort_cnt)
    );

    typedef struct {
        int          txn;
        logic [1:0]  wi;
        logic [1:0]  ri;
        logic [28:0] wa;
        logic [28:0] ra;
        logic        rv;
        logic        nf;
        logic        rp;
        logic [15:0] wc;
        logic [15:0] rc;
        logic [15:0] ac;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    // Reference model state: who holds what, as plain integers.
    bit          m_wact, m_ract, m_lv, m_rv, m_nf, m_rp;
    int          m_wi, m_ri, m_latest;
    logic [15:0] m_wc, m_rc, m_ac;

    task automatic cmp(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s txn=%0d actual=0x%0h required=0x%0h", name, t, act, exp);
        end
    endtask

    // Writer picks the free buffer closest (circularly) after the one it holds.
    function automatic int pick_buffer();
        int best = 0;
        int bestd = 1000;
        for (int b = 0; b < NF; b++) begin
            bit free = 1'b1;
            int d;
            if (m_ract && b == m_ri) free = 1'b0;
            if (m_lv && b == m_latest) free = 1'b0;
            d = (b - (m_wi + 1) + 2 * NF) % NF;
            if (free && d < bestd) begin
                bestd = d;
                best  = b;
            end
        end
        return best;
    endfunction

    task automatic model_step(input bit rstn, input bit en, input bit wd,
                              input bit rs, input bit rdn, input bit ws);
        exp_t e;
        m_nf = 1'b0;
        m_rp = 1'b0;
        if (!rstn) begin
            m_wact = 0; m_ract = 0; m_lv = 0; m_rv = 0;
            m_wi = NF - 1; m_ri = 0; m_latest = 0;
            m_wc = '0; m_rc = '0; m_ac = '0;
        end else if (en) begin
            if (wd && m_wact) begin
                m_latest = m_wi;
                m_lv     = 1;
                m_wc     = m_wc + 16'd1;
                m_wact   = 0;
            end
            if (rdn) m_ract = 0;
            if (rs && m_lv) begin
                if (m_latest != m_ri || !m_rv) begin
                    m_ri = m_latest;
                    m_nf = 1;
                end else begin
                    m_rp = 1;
                    m_rc = m_rc + 16'd1;
                end
                m_rv   = 1;
                m_ract = 1;
            end
            if (ws) begin
                if (m_wact) m_ac = m_ac + 16'd1;
                m_wi   = pick_buffer();
                m_wact = 1;
            end
        end
        e.txn = txn_no;
        e.wi  = 2'(m_wi);
        e.ri  = 2'(m_ri);
        e.wa  = 29'(m_wi * 32'h0010_0000);
        e.ra  = 29'(m_ri * 32'h0010_0000);
        e.rv  = m_rv;
        e.nf  = m_nf;
        e.rp  = m_rp;
        e.wc  = m_wc;
        e.rc  = m_rc;
        e.ac  = m_ac;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs (called just after a falling edge), queue the
    // expectation, and return at the next falling edge.
    task automatic step(input bit rstn, input bit en, input bit wd, input bit rs,
                        input bit rdn, input bit ws);
        axi_resetn     = rstn;
        enable         = en;
        wr_frame_done  = wd;
        rd_frame_start = rs;
        rd_frame_done  = rdn;
        wr_frame_start = ws;
        model_step(rstn, en, wd, rs, rdn, ws);
        txn_no++;
        @(negedge clk);
    endtask

    // Monitor: one snapshot per clock, one line per transaction.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            cmp("wr_index",       mon_e.txn, 32'(wr_index),       32'(mon_e.wi));
            cmp("rd_index",       mon_e.txn, 32'(rd_index),       32'(mon_e.ri));
            cmp("wr_base_addr",   mon_e.txn, 32'(wr_base_addr),   32'(mon_e.wa));
            cmp("rd_base_addr",   mon_e.txn, 32'(rd_base_addr),   32'(mon_e.ra));
            cmp("rd_frame_valid", mon_e.txn, 32'(rd_frame_valid), 32'(mon_e.rv));
            cmp("rd_new_frame",   mon_e.txn, 32'(rd_new_frame),   32'(mon_e.nf));
            cmp("rd_repeat",      mon_e.txn, 32'(rd_repeat),      32'(mon_e.rp));
            cmp("wr_frame_cnt",   mon_e.txn, 32'(wr_frame_cnt),   32'(mon_e.wc));
            cmp("rd_repeat_cnt",  mon_e.txn, 32'(rd_repeat_cnt),  32'(mon_e.rc));
            cmp("wr_abort_cnt",   mon_e.txn, 32'(wr_abort_cnt),   32'(mon_e.ac));
            $display("txn %0d: wi=%0d ri=%0d rv=%0b nf=%0b rp=%0b wc=%0d rc=%0d ac=%0d",
                     mon_e.txn, wr_index, rd_index, rd_frame_valid, rd_new_frame,
                     rd_repeat, wr_frame_cnt, rd_repeat_cnt, wr_abort_cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_resetn = 1'b0; enable = 1'b1;
        wr_frame_start = 0; wr_frame_done = 0; rd_frame_start = 0; rd_frame_done = 0;

        // Reset                 rstn en wd rs rdn ws
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        cmp("reset_wr_index", txn_no, 32'(wr_index), 32'd2);
        cmp("reset_rd_valid", txn_no, 32'(rd_frame_valid), 32'd0);

        // 1: reader start with nothing published, then first writer start
        step(1, 1, 0, 1, 0, 0);
        cmp("t1_no_valid", txn_no, 32'(rd_frame_valid), 32'd0);
        cmp("t1_no_pulse", txn_no, 32'(rd_new_frame), 32'd0);
        step(1, 1, 0, 0, 0, 1);
        cmp("t1_wr_index", txn_no, 32'(wr_index), 32'd0);
        cmp("t1_wr_base",  txn_no, 32'(wr_base_addr), 32'h0);

        // 2: publish buffer 0 and read it
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        cmp("t2_rd_index",  txn_no, 32'(rd_index), 32'd0);
        cmp("t2_new_frame", txn_no, 32'(rd_new_frame), 32'd1);
        cmp("t2_wr_cnt",    txn_no, 32'(wr_frame_cnt), 32'd1);
        step(1, 1, 0, 0, 0, 0);
        cmp("t2_pulse_one", txn_no, 32'(rd_new_frame), 32'd0);

        // 3: reader holds 0; writer cycles 1, 2, 1
        step(1, 1, 0, 0, 0, 1);
        cmp("t3_wi_a", txn_no, 32'(wr_index), 32'd1);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        cmp("t3_wi_b", txn_no, 32'(wr_index), 32'd2);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        cmp("t3_wi_c", txn_no, 32'(wr_index), 32'd1);
        step(1, 1, 1, 0, 0, 0);

        // 4: pick up frame 1, then restart with nothing new -> repeat
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0);
        cmp("t4_new_idx", txn_no, 32'(rd_index), 32'd1);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0);
        cmp("t4_repeat",     txn_no, 32'(rd_repeat), 32'd1);
        cmp("t4_repeat_cnt", txn_no, 32'(rd_repeat_cnt), 32'd1);
        cmp("t4_rd_index",   txn_no, 32'(rd_index), 32'd1);

        // 5: writer on 2; done and reader start together
        step(1, 1, 0, 0, 0, 1);
        cmp("t5_wi", txn_no, 32'(wr_index), 32'd2);
        step(1, 1, 1, 1, 0, 0);
        cmp("t5_rd_index", txn_no, 32'(rd_index), 32'd2);
        cmp("t5_rd_base",  txn_no, 32'(rd_base_addr), 32'h200000);
        // abort: two starts without a done
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        cmp("t5_abort_cnt", txn_no, 32'(wr_abort_cnt), 32'd1);
        // back-to-back frame: done + start in one cycle
        step(1, 1, 1, 0, 0, 1);

        // 6: enable low with all pulses, then reset mid-frame
        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        cmp("t6_reset_wi",  txn_no, 32'(wr_index), 32'd2);
        cmp("t6_reset_cnt", txn_no, 32'(wr_frame_cnt), 32'd0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0));
        end
        step(1, 1, 0, 0, 0, 0);

        cmp("scoreboard_drained", txn_no, 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
